// File: rtl/lfsr_tick_timer_pkg.sv
// Shared constants for the LFSR tick timer: width limits, Galois tap masks
// and the FSM state encoding.
package lfsr_tick_pkg;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Low-order coefficients of a primitive polynomial for each width; x^WIDTH is implied.
  localparam logic [WIDTH_MAX-1:0] TAPS [WIDTH_MIN:WIDTH_MAX] = '{
    16'h0003,  // 4 : x^4+x+1
    16'h0005,  // 5 : x^5+x^2+1
    16'h0003,  // 6 : x^6+x+1
    16'h0003,  // 7 : x^7+x+1
    16'h001D,  // 8 : x^8+x^4+x^3+x^2+1
    16'h0011,  // 9 : x^9+x^4+1
    16'h0009,  // 10: x^10+x^3+1
    16'h0005,  // 11: x^11+x^2+1
    16'h0053,  // 12: x^12+x^6+x^4+x+1
    16'h001B,  // 13: x^13+x^4+x^3+x+1
    16'h002B,  // 14: x^14+x^5+x^3+x+1
    16'h0003,  // 15: x^15+x+1
    16'h100B   // 16: x^16+x^12+x^3+x+1
  };

endpackage

// File: rtl/lfsr_tick_timer_if.sv
// Control/status bundle of the LFSR tick timer. The TickCount signal exists only
// when LFSR_TICK_COUNT_EN is defined.
interface lfsr_tick_timer_if #(
  parameter int WIDTH = 7
);
  logic             enable_i;
  logic             start_i;
  logic             mode_i;
  logic [WIDTH-1:0] terminal_i;
  logic             tick_o;
  logic             busy_o;
  logic             done_o;
  logic             config_error_o;
`ifdef LFSR_TICK_COUNT_EN
  logic [15:0]      tick_count_o;

  modport master (
    output enable_i, start_i, mode_i, terminal_i,
    input  tick_o, busy_o, done_o, config_error_o, tick_count_o
  );
  modport slave (
    input  enable_i, start_i, mode_i, terminal_i,
    output tick_o, busy_o, done_o, config_error_o, tick_count_o
  );
`else
  modport master (
    output enable_i, start_i, mode_i, terminal_i,
    input  tick_o, busy_o, done_o, config_error_o
  );
  modport slave (
    input  enable_i, start_i, mode_i, terminal_i,
    output tick_o, busy_o, done_o, config_error_o
  );
`endif
endinterface

// File: rtl/lfsr_tick_timer_lfsr_core.sv
// Galois LFSR register with synchronous load of SEED and single-step advance.
// Load wins over step.
module lfsr_core
  import lfsr_tick_pkg::*;
#(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic             load_i,
  output logic [WIDTH-1:0] state_o
);
  localparam logic [WIDTH_MAX-1:0] TAP_FULL = TAPS[WIDTH];
  localparam logic [WIDTH-1:0]     TAP_MASK = TAP_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;
  logic [WIDTH-1:0] stepped;
  logic             fb;

  assign fb = lfsr_q[WIDTH-1];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (gi == 0) begin : g_lsb
      assign stepped[gi] = fb & TAP_MASK[gi];
    end else begin : g_upper
      assign stepped[gi] = lfsr_q[gi-1] ^ (fb & TAP_MASK[gi]);
    end
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (step_i) begin
      lfsr_d = stepped;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/lfsr_tick_timer.sv
// LFSR-based tick timer: periodic or one-shot ticks when the LFSR reaches a
// programmed terminal pattern. Define LFSR_TICK_COUNT_EN to add a 16-bit tick counter.
module lfsr_tick_timer
  import lfsr_tick_pkg::*;
#(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic              clk,
  input  logic              rst,
  lfsr_tick_timer_if.slave  bus
);
  state_e           state_q;
  logic [WIDTH-1:0] term_q;
  logic             mode_q;
  logic             tick_q;
  logic             busy_q;
  logic             done_q;
  logic             cerr_q;
  logic [WIDTH-1:0] lfsr_state;
  logic             start_ok;
  logic             start_bad;
  logic             match;
  logic             run_en;

  // An all-zero terminal can never be reached by a maximal-length LFSR, so it is rejected.
  assign start_ok  = bus.start_i && (bus.terminal_i != '0);
  assign start_bad = bus.start_i && (bus.terminal_i == '0);
  assign run_en    = (state_q == ST_RUN) && bus.enable_i;
  assign match     = run_en && (lfsr_state == term_q);

  lfsr_core #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .step_i  (run_en),
    .load_i  (start_ok || match),
    .state_o (lfsr_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      term_q  <= SEED;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      cerr_q <= start_bad;
      if (start_ok) begin
        term_q  <= bus.terminal_i;
        mode_q  <= bus.mode_i;
        state_q <= ST_RUN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else if (match) begin
        tick_q <= 1'b1;
        if (mode_q) begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.tick_o         = tick_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.config_error_o = cerr_q;

`ifdef LFSR_TICK_COUNT_EN
  logic [15:0] tick_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_count_q <= 16'd0;
    end else if (start_ok) begin
      tick_count_q <= 16'd0;
    end else if (match) begin
      tick_count_q <= tick_count_q + 16'd1;
    end
  end

  assign bus.tick_count_o = tick_count_q;
`endif

endmodule

// File: tb/tb_lfsr_tick_timer.sv
// Self-checking bench for lfsr_tick_timer (WIDTH=7, SEED=7F): directed scenarios
// followed by randomized transactions, all compared against a period-based model.
module tb_lfsr_tick_timer;
  localparam int             W      = 7;
  localparam logic [W-1:0]   SEED_V = 7'h7F;
  localparam int             SEQLEN = 127;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  lfsr_tick_timer_if #(.WIDTH(W)) bus ();

  lfsr_tick_timer #(
    .WIDTH (W),
    .SEED  (SEED_V)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: seq[i] is SEED advanced i steps; a run ticks every (index of Terminal)+1 enabled cycles.
  logic [W-1:0] seq [0:SEQLEN-1];
  bit           m_run, m_oneshot, m_done, m_tick, m_cerr;
  int           m_idx, m_period, m_cnt;

  function automatic logic [W-1:0] spec_step(logic [W-1:0] v);
    logic [W-1:0] taps;
    taps = 7'h03;
    return {v[W-2:0], 1'b0} ^ (v[W-1] ? taps : '0);
  endfunction

  function automatic int period_of(logic [W-1:0] t);
    for (int i = 0; i < SEQLEN; i++) begin
      if (seq[i] == t) return i + 1;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_oneshot = 0; m_done = 0; m_tick = 0; m_cerr = 0;
    m_idx = 0; m_period = 1; m_cnt = 0;
  endtask

  task automatic model_edge();
    m_tick = 0;
    m_cerr = 0;
    if (bus.start_i && bus.terminal_i != '0) begin
      m_run = 1; m_done = 0; m_oneshot = bus.mode_i;
      m_period = period_of(bus.terminal_i);
      m_idx = 0; m_cnt = 0;
    end else begin
      if (bus.start_i) m_cerr = 1;
      if (m_run && bus.enable_i) begin
        if (m_idx == m_period - 1) begin
          m_tick = 1;
          m_idx  = 0;
          m_cnt  = (m_cnt + 1) % 65536;
          if (m_oneshot) begin
            m_run  = 0;
            m_done = 1;
          end
        end else begin
          m_idx++;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("tick", 16'(bus.tick_o), 16'(m_tick));
    check("busy", 16'(bus.busy_o), 16'(m_run));
    check("done", 16'(bus.done_o), 16'(m_done));
    check("config_error", 16'(bus.config_error_o), 16'(m_cerr));
    check("lfsr", 16'(dut.lfsr_state), 16'(seq[m_idx]));
`ifdef LFSR_TICK_COUNT_EN
    check("tick_count", bus.tick_count_o, 16'(m_cnt));
`endif
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_start(input logic [W-1:0] term, input logic mode);
    bus.start_i    = 1'b1;
    bus.terminal_i = term;
    bus.mode_i     = mode;
    cycle();
    bus.start_i    = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [W-1:0] v;
    int           ticks;
    v = SEED_V;
    for (int i = 0; i < SEQLEN; i++) begin
      seq[i] = v;
      v = spec_step(v);
    end

    bus.enable_i = 1'b0; bus.start_i = 1'b0; bus.mode_i = 1'b0; bus.terminal_i = '0;
    model_reset();

    // Reset state
    @(posedge clk); #1;
    compare_all();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    compare_all();
    $display("txn reset: outputs idle, lfsr=%h", dut.lfsr_state);

    // Periodic, Terminal one step past SEED: tick every 2nd cycle
    bus.enable_i = 1'b1;
    do_start(7'h7D, 1'b0);
    check("run_lfsr_first", 16'(dut.lfsr_state), 16'h007F);
    cycle();
    check("run_lfsr_second", 16'(dut.lfsr_state), 16'h007D);
    cycle();
    check("run_lfsr_reload", 16'(dut.lfsr_state), 16'h007F);
    check("run_tick_period2", 16'(bus.tick_o), 16'h0001);
    run_cycles(6);
    $display("txn periodic term=7D done");

    // Terminal == SEED: tick on every enabled cycle
    do_start(7'h7F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("every_cycle_tick", 16'(bus.tick_o), 16'h0001);
    end
    $display("txn periodic term=7F done");

    // One-shot: single tick, then Done sticky and Busy low
    do_start(7'h7D, 1'b1);
    run_cycles(2);
    check("oneshot_tick", 16'(bus.tick_o), 16'h0001);
    run_cycles(3);
    check("oneshot_done", 16'(bus.done_o), 16'h0001);
    check("oneshot_busy", 16'(bus.busy_o), 16'h0000);

    // Rejected start while DONE: error pulse only
    do_start(7'h00, 1'b0);
    check("cfgerr_pulse", 16'(bus.config_error_o), 16'h0001);
    check("cfgerr_busy", 16'(bus.busy_o), 16'h0000);
    cycle();
    check("cfgerr_one_cycle", 16'(bus.config_error_o), 16'h0000);

    // Restart clears Done
    do_start(7'h7D, 1'b0);
    check("restart_clears_done", 16'(bus.done_o), 16'h0000);
    $display("txn oneshot/config-error/restart done");

    // Enable pattern 1,0,0,1 delays the tick by two cycles
    bus.enable_i = 1'b1; cycle();
    bus.enable_i = 1'b0; cycle();
    check("hold_lfsr", 16'(dut.lfsr_state), 16'h007D);
    cycle();
    bus.enable_i = 1'b1; cycle();
    check("delayed_tick", 16'(bus.tick_o), 16'h0001);
    $display("txn enable gating done");

    // Asynchronous reset between edges aborts the run
    do_start(7'h79, 1'b0);
    run_cycles(2);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_busy", 16'(bus.busy_o), 16'h0000);
    check("async_lfsr", 16'(dut.lfsr_state), 16'h007F);
    check("async_tick", 16'(bus.tick_o), 16'h0000);
    #1 rst = 1'b0;
    ticks = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      ticks += int'(bus.tick_o);
    end
    check("post_reset_no_tick", 16'(ticks), 16'h0000);
    $display("txn async reset done");

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] term;
      logic         mode;
      int           len;
      case ($urandom_range(0, 7))
        0:       term = 7'h00;
        1:       term = 7'h7F;
        2:       term = 7'h7D;
        default: term = W'($urandom_range(1, 127));
      endcase
      mode = 1'($urandom_range(0, 1));
      len  = $urandom_range(10, 140);
      bus.enable_i = 1'b1;
      do_start(term, mode);
      for (int c = 0; c < len; c++) begin
        bus.enable_i = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 63) == 0) begin
          bus.start_i    = 1'b1;
          bus.terminal_i = W'($urandom_range(0, 127));
          bus.mode_i     = 1'($urandom_range(0, 1));
        end
        cycle();
        bus.start_i = 1'b0;
      end
      $display("txn random %0d term=%h mode=%0d len=%0d period=%0d", t, term, mode, len, m_period);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_tick_timer.md
LFSR_TICK_TIMER -- requirements
Module: lfsr_tick_timer

Interface
- REQ-001: Parameter WIDTH, default 7, SHALL set the LFSR width; legal range 4..16.
- REQ-002: Parameter SEED, default all-ones, SHALL set the LFSR reload value; it SHALL be non-zero.
- REQ-003: Clock  input  1  the single clock; all state SHALL update on its rising edge.
- REQ-004: Reset  input  1  asynchronous, active-high reset.
- REQ-005: EnableSignal  input  1  advances the LFSR by one step per cycle while high.
- REQ-006: Start  input  1  single-cycle pulse that samples Terminal and Mode and starts counting.
- REQ-007: Mode  input  1  count mode: 0 = periodic, 1 = one-shot.
- REQ-008: Terminal  input  WIDTH  LFSR pattern at which a tick fires.
- REQ-009: Tick  output  1  one-cycle pulse at each terminal match.
- REQ-010: Busy  output  1  high while in RUN.
- REQ-011: Done  output  1  sticky one-shot completion flag.
- REQ-012: ConfigError  output  1  one-cycle pulse when a Start is rejected.

Function
- REQ-013: The FSM SHALL have three states, IDLE, RUN and DONE, with IDLE as the reset state.
- REQ-014: LFSR step, Galois form: fb = L[WIDTH-1]; next = {L[WIDTH-2:0],1'b0} XOR (fb ? TAPS[WIDTH] : 0).
- REQ-015: TAPS[7] SHALL equal 7'b000_0011; every TAPS entry SHALL be a maximal-length polynomial.
- REQ-016: On Start with Terminal != 0, the block SHALL:
  - latch Terminal and Mode;
  - load the LFSR with SEED;
  - enter RUN on the next cycle;
  - clear Done.
- REQ-017: On Start with Terminal == 0, which is unreachable, Start SHALL be ignored, the state SHALL be unchanged, and ConfigError SHALL pulse for 1 cycle.
- REQ-018: In RUN with EnableSignal = 1 and L == latched Terminal, the block SHALL:
  - reload the LFSR with SEED;
  - register Tick = 1 for exactly 1 cycle;
  - in one-shot mode only, go to DONE and set Done.
- REQ-019: In RUN with EnableSignal = 1 and no match, the LFSR SHALL step and Tick SHALL be 0.
- REQ-020: With EnableSignal = 0, the LFSR and the FSM SHALL hold and Tick SHALL be 0.
- REQ-021: Tick period in enabled cycles SHALL equal (steps from SEED to Terminal) + 1.
  - Terminal == SEED SHALL give a Tick on every enabled cycle.
- REQ-022: Start in RUN or DONE SHALL restart per REQ-016; Start SHALL take priority over a same-cycle match, and no Tick SHALL be issued in that cycle.
- REQ-023: In IDLE and DONE, Tick SHALL be 0 and the LFSR SHALL hold.
- REQ-024: Tick, Done, Busy and ConfigError SHALL all be registered outputs.

Reset
- REQ-025: Reset SHALL asynchronously force:
  - the FSM to IDLE;
  - the LFSR to SEED;
  - latched Terminal to SEED and Mode to 0;
  - Tick, Busy, Done and ConfigError to 0.
- REQ-026: Reset asserted mid-RUN SHALL abort the run with no Tick; after release, a new Start SHALL be required.

Configuration
- REQ-027: With LFSR_TICK_COUNT_EN defined, the block SHALL add output TickCount (16 bits):
  - reset to 0;
  - cleared on an accepted Start;
  - incremented on each Tick;
  - wraps from 16'hFFFF to 0.
- REQ-028: Without LFSR_TICK_COUNT_EN, there SHALL be no TickCount port and no counter logic.

Structure
- REQ-029: Package lfsr_tick_pkg SHALL hold:
  - the TAPS table indexed by width 4..16;
  - the FSM state encoding (IDLE = 0, RUN = 1, DONE = 2);
  - the WIDTH_MIN and WIDTH_MAX constants.
- REQ-030: Sub-module lfsr_core (WIDTH, SEED) SHALL own the LFSR register, with inputs step and load and output state.

Verification
- REQ-031: WIDTH=7, SEED=7'h7F, Start with Terminal=7'h7D, Mode=0, EnableSignal held at 1 -> Tick on every 2nd cycle; LFSR sequence 7F, 7D, 7F.
- REQ-032: Terminal=7'h7F, Mode=0 -> Tick on every cycle from the first RUN cycle.
- REQ-033: Terminal=7'h7D, Mode=1 -> exactly one Tick, then Done=1 and Busy=0; a second Start clears Done.
- REQ-034: Terminal=7'h00 on Start -> ConfigError pulses 1 cycle and Busy stays 0.
- REQ-035: EnableSignal toggles 1,0,0,1 during RUN -> the LFSR holds on the 0 cycles and the Tick is delayed by 2 cycles.
- REQ-036: Reset pulsed mid-RUN, asynchronously between edges -> Busy=0 and LFSR=7F immediately, with no Tick.
